// File: rtl/bubble_page_streamer.sv
// Double-banked page buffer: a loader fills one bank while the other streams out on CHANNELS bubble lanes.
// Optional build macro BUBBLE_STREAMER_UNDERRUN_COUNT_EN adds a saturating 8-bit underrun_count output.
//
// stream FSM:
//   state     | meaning
//   ST_IDLE   | no page active; strobes drive IDLE_LEVEL, start_page picks a FULL bank
//   ST_STREAM | reading the READING bank one word per data_out_strobe
//
// bank state:
//   state        | meaning
//   BANK_EMPTY   | free, will be handed to the loader
//   BANK_FILLING | owned by the loader, accepts writes
//   BANK_FULL    | complete page waiting for start_page
//   BANK_READING | page being streamed
module bubble_page_streamer #(
    parameter int   CHANNELS   = 2,
    parameter int   ADDR_W     = 10,
    parameter int   PAGE_LEN   = 1024,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                master_clock,
    input  logic                reset,
    output logic                fill_request,
    output logic                fill_bank,
    input  logic                buffer_write_enable,
    input  logic [ADDR_W-1:0]   buffer_write_address,
    input  logic [CHANNELS-1:0] buffer_write_data,
    input  logic                fill_done,
    input  logic                start_page,
    input  logic                data_out_strobe,
    output logic [CHANNELS-1:0] bubble_out,
    output logic                streaming,
`ifdef BUBBLE_STREAMER_UNDERRUN_COUNT_EN
    output logic [7:0]          underrun_count,
`endif
    output logic                underrun
);

    localparam logic [1:0] BANK_EMPTY   = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_FULL    = 2'd2;
    localparam logic [1:0] BANK_READING = 2'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_LEN - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [CHANNELS-1:0] r_mem0 [DEPTH];
    logic [CHANNELS-1:0] r_mem1 [DEPTH];

    logic [1:0][1:0]     r_bank_st;
    logic [1:0][1:0]     w_bank_nxt;
    logic [0:0]          r_fsm;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic                r_rd_bank;
    logic                r_fill_bank;
    logic                r_fill_arm;
    logic                r_fill_req;
    logic                r_older;
    logic [CHANNELS-1:0] r_bubble;
    logic                r_underrun;

    logic                w_fill0;
    logic                w_fill1;
    logic                w_full0;
    logic                w_full1;
    logic                w_any_filling;
    logic                w_any_full;
    logic                w_alloc;
    logic                w_alloc_bank;
    logic                w_done;
    logic                w_filling_bank;
    logic                w_pick_bank;
    logic                w_start;
    logic                w_underrun_evt;
    logic                w_advance;
    logic                w_page_end;
    logic [CHANNELS-1:0] w_rd_word;

    assign w_fill0        = (r_bank_st[0] == BANK_FILLING);
    assign w_fill1        = (r_bank_st[1] == BANK_FILLING);
    assign w_full0        = (r_bank_st[0] == BANK_FULL);
    assign w_full1        = (r_bank_st[1] == BANK_FULL);
    assign w_any_filling  = w_fill0 | w_fill1;
    assign w_any_full     = w_full0 | w_full1;

    assign w_alloc        = !w_any_filling &&
                            ((r_bank_st[0] == BANK_EMPTY) || (r_bank_st[1] == BANK_EMPTY));
    assign w_alloc_bank   = (r_bank_st[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    assign w_done         = fill_done && w_any_filling;
    assign w_filling_bank = w_fill1;

    // With both banks FULL the older page wins; otherwise the single FULL bank.
    assign w_pick_bank    = (w_full0 && w_full1) ? r_older : w_full1;

    assign w_start        = (r_fsm == ST_IDLE) && start_page && w_any_full;
    assign w_underrun_evt = (r_fsm == ST_IDLE) && start_page && !w_any_full;
    assign w_advance      = (r_fsm == ST_STREAM) && data_out_strobe;
    assign w_page_end     = w_advance && (r_rd_ptr == LAST_ADDR);
    assign w_rd_word      = r_rd_bank ? r_mem1[r_rd_ptr] : r_mem0[r_rd_ptr];

    // Each event touches a different bank, so applying them in sequence never collides.
    always_comb begin
        w_bank_nxt = r_bank_st;
        if (w_alloc)
            w_bank_nxt[w_alloc_bank] = BANK_FILLING;
        if (w_done)
            w_bank_nxt[w_filling_bank] = BANK_FULL;
        if (w_start)
            w_bank_nxt[w_pick_bank] = BANK_READING;
        if (w_page_end)
            w_bank_nxt[r_rd_bank] = BANK_EMPTY;
    end

    always_ff @(posedge master_clock) begin
        if (buffer_write_enable && w_fill0)
            r_mem0[buffer_write_address] <= buffer_write_data;
        if (buffer_write_enable && w_fill1)
            r_mem1[buffer_write_address] <= buffer_write_data;
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            r_bank_st   <= {BANK_EMPTY, BANK_EMPTY};
            r_older     <= 1'b0;
            r_fill_bank <= 1'b0;
            r_fill_arm  <= 1'b0;
            r_fill_req  <= 1'b0;
        end else begin
            r_bank_st <= w_bank_nxt;
            if (w_done && (r_bank_st[~w_filling_bank] != BANK_FULL))
                r_older <= w_filling_bank;
            // Allocation registers fill_bank; the request follows one cycle later.
            if (w_done) begin
                r_fill_req <= 1'b0;
                r_fill_arm <= 1'b0;
            end else if (w_alloc) begin
                r_fill_bank <= w_alloc_bank;
                r_fill_arm  <= 1'b1;
            end else if (r_fill_arm) begin
                r_fill_req <= 1'b1;
                r_fill_arm <= 1'b0;
            end
        end
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            r_fsm      <= ST_IDLE;
            r_rd_ptr   <= '0;
            r_rd_bank  <= 1'b0;
            r_bubble   <= {CHANNELS{IDLE_LEVEL}};
            r_underrun <= 1'b0;
        end else begin
            if (w_start) begin
                r_fsm     <= ST_STREAM;
                r_rd_ptr  <= '0;
                r_rd_bank <= w_pick_bank;
            end
            if (w_advance) begin
                r_bubble <= w_rd_word;
                if (w_page_end) begin
                    r_fsm    <= ST_IDLE;
                    r_rd_ptr <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end else if ((r_fsm == ST_IDLE) && data_out_strobe) begin
                r_bubble <= {CHANNELS{IDLE_LEVEL}};
            end
            if (w_underrun_evt)
                r_underrun <= 1'b1;
        end
    end

`ifdef BUBBLE_STREAMER_UNDERRUN_COUNT_EN
    logic [7:0] r_urun_cnt;

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset)
            r_urun_cnt <= 8'd0;
        else if (w_underrun_evt && (r_urun_cnt != 8'hFF))
            r_urun_cnt <= r_urun_cnt + 8'd1;
    end

    assign underrun_count = r_urun_cnt;
`endif

    assign fill_request = r_fill_req;
    assign fill_bank    = r_fill_bank;
    assign bubble_out   = r_bubble;
    assign streaming    = (r_fsm == ST_STREAM);
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_bubble_page_streamer.sv
// Directed bench for bubble_page_streamer: fill, stream, bank ordering, coincident events, reset.
// Underrun counter checks are active when BUBBLE_STREAMER_UNDERRUN_COUNT_EN is defined.
module tb_bubble_page_streamer;

    localparam int CH = 2;
    localparam int AW = 10;
    localparam int PL = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [CH-1:0] wdata = '0;
    logic          fdone = 1'b0;
    logic          spage = 1'b0;
    logic          strobe = 1'b0;
    logic          freq;
    logic          fbank;
    logic [CH-1:0] bout;
    logic          strm;
    logic          urun;
`ifdef BUBBLE_STREAMER_UNDERRUN_COUNT_EN
    logic [7:0]    ucnt;
`endif

    int total = 0;
    int bad   = 0;

    bubble_page_streamer #(
        .CHANNELS(CH), .ADDR_W(AW), .PAGE_LEN(PL), .IDLE_LEVEL(1'b0)
    ) dut (
        .master_clock        (clk),
        .reset               (rst),
        .fill_request        (freq),
        .fill_bank           (fbank),
        .buffer_write_enable (we),
        .buffer_write_address(waddr),
        .buffer_write_data   (wdata),
        .fill_done           (fdone),
        .start_page          (spage),
        .data_out_strobe     (strobe),
        .bubble_out          (bout),
        .streaming           (strm),
`ifdef BUBBLE_STREAMER_UNDERRUN_COUNT_EN
        .underrun_count      (ucnt),
`endif
        .underrun            (urun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pattern(input int pat, input int n);
        logic [AW-1:0] a;
        a = AW'(n);
        case (pat)
            0:       return a[1:0];
            1:       return ~a[1:0];
            2:       return a[2:1];
            default: return a[1:0] ^ 2'b01;
        endcase
    endfunction

    task automatic load_bank(input int pat);
        for (int n = 0; n < PL; n++) begin
            we = 1'b1; waddr = AW'(n); wdata = pattern(pat, n);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic wait_fill_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (freq) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL rst_fill_request: got %b expected 0", freq); end
        total++; if (fbank !== 1'b0) begin bad++; $display("FAIL rst_fill_bank: got %b expected 0", fbank); end
        total++; if (bout !== 2'b00) begin bad++; $display("FAIL rst_bubble_out: got %b expected 00", bout); end
        total++; if (strm !== 1'b0) begin bad++; $display("FAIL rst_streaming: got %b expected 0", strm); end
        total++; if (urun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b expected 0", urun); end
        rst = 1'b0;
        tick();
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL req_edge1: got %b expected 0", freq); end
        tick();
        total++; if (freq !== 1'b1) begin bad++; $display("FAIL req_edge2: got %b expected 1", freq); end
        total++; if (fbank !== 1'b0) begin bad++; $display("FAIL req_edge2_bank: got %b expected 0", fbank); end
    endtask

    task automatic test_underrun();
        rst = 1'b1; tick(); rst = 1'b0;
        spage = 1'b1; tick(); spage = 1'b0;
        total++; if (urun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b expected 1", urun); end
        total++; if (strm !== 1'b0) begin bad++; $display("FAIL underrun_streaming: got %b expected 0", strm); end
        total++; if (bout !== 2'b00) begin bad++; $display("FAIL underrun_bubble: got %b expected 00", bout); end
`ifdef BUBBLE_STREAMER_UNDERRUN_COUNT_EN
        total++; if (ucnt !== 8'd1) begin bad++; $display("FAIL underrun_count_1: got %0d expected 1", ucnt); end
        for (int i = 0; i < 299; i++) begin
            spage = 1'b1; tick(); spage = 1'b0; tick();
        end
        total++; if (ucnt !== 8'd255) begin bad++; $display("FAIL underrun_count_sat: got %0d expected 255", ucnt); end
`endif
        rst = 1'b1; #1;
        total++; if (urun !== 1'b0) begin bad++; $display("FAIL underrun_clear: got %b expected 0", urun); end
        tick(); rst = 1'b0;
    endtask

    task automatic test_fill0();
        bit ok;
        wait_fill_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL fill0_wait: fill_request=%b expected 1 within 20 cycles", freq); end
        total++; if (fbank !== 1'b0) begin bad++; $display("FAIL fill0_bank: got %b expected 0", fbank); end
        load_bank(0);
        fdone = 1'b1; tick(); fdone = 1'b0;
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL fill0_drop: got %b expected 0", freq); end
        tick();
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL fill0_gap: got %b expected 0", freq); end
        tick();
        total++; if (freq !== 1'b1) begin bad++; $display("FAIL fill1_req: got %b expected 1", freq); end
        total++; if (fbank !== 1'b1) begin bad++; $display("FAIL fill1_bank: got %b expected 1", fbank); end
    endtask

    task automatic test_stream_page();
        spage = 1'b1; tick(); spage = 1'b0;
        total++; if (strm !== 1'b1) begin bad++; $display("FAIL stream_start: got %b expected 1", strm); end
        for (int k = 0; k < PL; k++) begin
            strobe = 1'b1; tick(); strobe = 1'b0;
            total++; if (bout !== pattern(0, k)) begin bad++; $display("FAIL stream_word_%0d: got %0d expected %0d", k, bout, pattern(0, k)); end
            if (k == PL - 2) begin
                total++; if (strm !== 1'b1) begin bad++; $display("FAIL stream_before_last: got %b expected 1", strm); end
            end
            if (k == PL - 1) begin
                total++; if (strm !== 1'b0) begin bad++; $display("FAIL stream_fall: got %b expected 0", strm); end
            end
            if (k == 100) begin
                spage = 1'b1; tick(); spage = 1'b0;
                total++; if (strm !== 1'b1) begin bad++; $display("FAIL start_ignored: got %b expected 1", strm); end
                repeat (6) tick();
            end else begin
                repeat (7) tick();
            end
        end
        total++; if (bout !== 2'd3) begin bad++; $display("FAIL last_word_hold: got %0d expected 3", bout); end
        strobe = 1'b1; tick(); strobe = 1'b0;
        total++; if (bout !== 2'd0) begin bad++; $display("FAIL idle_strobe: got %0d expected 0", bout); end
        total++; if (urun !== 1'b0) begin bad++; $display("FAIL stream_no_underrun: got %b expected 0", urun); end
    endtask

    task automatic test_fill_both();
        bit ok;
        load_bank(1);
        fdone = 1'b1; tick(); fdone = 1'b0;
        wait_fill_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL fillb_wait: fill_request=%b expected 1 within 20 cycles", freq); end
        total++; if (fbank !== 1'b0) begin bad++; $display("FAIL fillb_bank: got %b expected 0", fbank); end
        load_bank(2);
        fdone = 1'b1; tick(); fdone = 1'b0;
        repeat (3) tick();
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL both_full_no_req: got %b expected 0", freq); end
        // Stray writes with no bank filling; later word checks prove they were dropped.
        for (int n = 0; n < 2; n++) begin
            we = 1'b1; waddr = AW'(n); wdata = 2'b01; tick();
        end
        we = 1'b0;
    endtask

    task automatic test_bank_order();
        spage = 1'b1; tick(); spage = 1'b0;
        total++; if (strm !== 1'b1) begin bad++; $display("FAIL order_start: got %b expected 1", strm); end
        for (int k = 0; k < PL; k++) begin
            strobe = 1'b1; tick(); strobe = 1'b0; tick();
            total++; if (bout !== pattern(1, k)) begin bad++; $display("FAIL order_word_%0d: got %0d expected %0d", k, bout, pattern(1, k)); end
        end
        total++; if (strm !== 1'b0) begin bad++; $display("FAIL order_end: got %b expected 0", strm); end
    endtask

    task automatic test_coincident();
        bit ok;
        wait_fill_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL coin_wait: fill_request=%b expected 1 within 20 cycles", freq); end
        total++; if (fbank !== 1'b1) begin bad++; $display("FAIL coin_bank: got %b expected 1", fbank); end
        load_bank(3);
        spage = 1'b1; tick(); spage = 1'b0;
        total++; if (strm !== 1'b1) begin bad++; $display("FAIL coin_start: got %b expected 1", strm); end
        for (int k = 0; k < PL - 1; k++) begin
            strobe = 1'b1; tick(); strobe = 1'b0; tick();
            total++; if (bout !== pattern(2, k)) begin bad++; $display("FAIL coin_word_%0d: got %0d expected %0d", k, bout, pattern(2, k)); end
        end
        strobe = 1'b1; fdone = 1'b1; tick(); strobe = 1'b0; fdone = 1'b0;
        total++; if (bout !== pattern(2, PL - 1)) begin bad++; $display("FAIL coin_last_word: got %0d expected %0d", bout, pattern(2, PL - 1)); end
        total++; if (strm !== 1'b0) begin bad++; $display("FAIL coin_stream_end: got %b expected 0", strm); end
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL coin_req_drop: got %b expected 0", freq); end
        tick(); tick();
        spage = 1'b1; tick(); spage = 1'b0;
        total++; if (strm !== 1'b1) begin bad++; $display("FAIL coin_next_start: got %b expected 1", strm); end
        total++; if (urun !== 1'b0) begin bad++; $display("FAIL coin_no_underrun: got %b expected 0", urun); end
    endtask

    task automatic test_reset_mid_page();
        for (int k = 0; k < 500; k++) begin
            strobe = 1'b1; tick(); strobe = 1'b0; tick();
            total++; if (bout !== pattern(3, k)) begin bad++; $display("FAIL mid_word_%0d: got %0d expected %0d", k, bout, pattern(3, k)); end
        end
        #2; rst = 1'b1; #1;
        total++; if (strm !== 1'b0) begin bad++; $display("FAIL mid_rst_streaming: got %b expected 0", strm); end
        total++; if (bout !== 2'b00) begin bad++; $display("FAIL mid_rst_bubble: got %b expected 00", bout); end
        total++; if (freq !== 1'b0) begin bad++; $display("FAIL mid_rst_req: got %b expected 0", freq); end
        total++; if (fbank !== 1'b0) begin bad++; $display("FAIL mid_rst_bank: got %b expected 0", fbank); end
        tick(); rst = 1'b0;
        spage = 1'b1; tick(); spage = 1'b0;
        total++; if (urun !== 1'b1) begin bad++; $display("FAIL mid_rst_underrun: got %b expected 1", urun); end
        total++; if (strm !== 1'b0) begin bad++; $display("FAIL mid_rst_no_stream: got %b expected 0", strm); end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_fill0();
        test_stream_page();
        test_fill_both();
        test_bank_order();
        test_coincident();
        test_reset_mid_page();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
